median_scan_ctrl: RTL and testbench

Sequencing controller for the single-port 1-bit 240x180 image RAM (`flatMem`). It loads a raster-order binary image into the RAM through a valid/ready stream. It then scans every pixel, issues the 9 reads of its 3x3 neighbourhood, and emits the majority (binary median) result as a second raster-order stream. It is the sole master of the RAM port, so the load and filter phases never contend.

---
 rtl/median_scan_ctrl_pkg.sv | 24 ++
 rtl/median_scan_ctrl_if.sv | 24 ++
 rtl/median_scan_ctrl_tap_gen.sv | 48 ++++
 rtl/median_scan_ctrl.sv | 169 ++++++++++++++++
 tb/tb_median_scan_ctrl.sv | 342 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/median_scan_ctrl_pkg.sv
// Shared image geometry, FSM state type and 3x3 window tap constants for the median scan controller.
package median_pkg;

    localparam int unsigned IMWIDTH  = 240;
    localparam int unsigned IMHEIGHT = 180;

    // Majority threshold of the 9-tap binary window.
    localparam logic [3:0]  MAJORITY = 4'd5;
    localparam logic [3:0]  LAST_TAP = 4'd8;

    // Tap k sits at window column k%3 and row k/3; the neighbour offset is position minus one.
    localparam logic [1:0] TAP_COL [9] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};
    localparam logic [1:0] TAP_ROW [9] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2};

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        TAP,
        FLUSH,
        EMIT,
        FIN
    } state_t;

endpackage

// File: rtl/median_scan_ctrl_if.sv
// Pixel in/out streams and image RAM port of the median scan controller.
interface median_scan_ctrl_if;
    logic       pixInValid;
    logic       pixInReady;
    logic       pixIn;
    logic [7:0] memX;
    logic [7:0] memY;
    logic       memWrite;
    logic       memDataIn;
    logic       memDataOut;
    logic       pixOutValid;
    logic       pixOutReady;
    logic       pixOut;

    modport master (
        input  pixInValid, pixIn, memDataOut, pixOutReady,
        output pixInReady, memX, memY, memWrite, memDataIn, pixOutValid, pixOut
    );

    modport slave (
        output pixInValid, pixIn, memDataOut, pixOutReady,
        input  pixInReady, memX, memY, memWrite, memDataIn, pixOutValid, pixOut
    );
endinterface

// File: rtl/median_scan_ctrl_tap_gen.sv
// Combinational neighbour address for tap k of the 3x3 window around (x,y), always clamped to the image.
// MEDIAN_BORDER_CLAMP_EN: clamped border taps count; otherwise they are flagged out of range (zero padding).
module median_tap_gen
    import median_pkg::*;
#(
    parameter int unsigned WIDTH  = IMWIDTH,
    parameter int unsigned HEIGHT = IMHEIGHT
) (
    input  logic [7:0] x,
    input  logic [7:0] y,
    input  logic [3:0] k,
    output logic [7:0] addr_x,
    output logic [7:0] addr_y,
    output logic       in_range
);
    localparam logic [9:0] W     = 10'(WIDTH);
    localparam logic [9:0] H     = 10'(HEIGHT);
    localparam logic [7:0] X_MAX = 8'(WIDTH - 1);
    localparam logic [7:0] Y_MAX = 8'(HEIGHT - 1);

    logic [3:0] k_sel;
    logic [1:0] col;
    logic [1:0] row;
    logic [9:0] nx;
    logic [9:0] ny;
    logic       in_x;
    logic       in_y;

    assign k_sel = (k > LAST_TAP) ? LAST_TAP : k;
    assign col   = TAP_COL[k_sel];
    assign row   = TAP_ROW[k_sel];

    // A -1 offset at coordinate 0 wraps to 10'h3ff, so one unsigned compare catches both borders.
    assign nx   = {2'b00, x} + {8'd0, col} - 10'd1;
    assign ny   = {2'b00, y} + {8'd0, row} - 10'd1;
    assign in_x = (nx < W);
    assign in_y = (ny < H);

    assign addr_x = in_x ? nx[7:0] : ((col == 2'd0) ? 8'd0 : X_MAX);
    assign addr_y = in_y ? ny[7:0] : ((row == 2'd0) ? 8'd0 : Y_MAX);

`ifdef MEDIAN_BORDER_CLAMP_EN
    assign in_range = 1'b1;
`else
    assign in_range = in_x & in_y;
`endif

endmodule

// File: rtl/median_scan_ctrl.sv
// Loads a raster binary image into the 1-bit image RAM, then streams out its 3x3 majority-filtered image.
// Border handling is selected by MEDIAN_BORDER_CLAMP_EN (see median_tap_gen).
//   state | meaning
//   IDLE  | waiting for start
//   LOAD  | accepting input pixels, one RAM write per transfer
//   TAP   | issuing the 9 window reads for pixel (x,y)
//   FLUSH | accumulating the last tap's read data
//   EMIT  | presenting the majority result until accepted
//   FIN   | one-cycle done pulse
module median_scan_ctrl
    import median_pkg::*;
#(
    parameter int unsigned WIDTH  = IMWIDTH,
    parameter int unsigned HEIGHT = IMHEIGHT
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    median_scan_ctrl_if.master  bus,
    output logic                busy,
    output logic                done
);
    localparam logic [7:0] X_MAX = 8'(WIDTH - 1);
    localparam logic [7:0] Y_MAX = 8'(HEIGHT - 1);

    state_t     state_q, state_d;
    logic [7:0] x_q, x_d;
    logic [7:0] y_q, y_d;
    logic [3:0] tap_q, tap_d;
    logic [3:0] count_q, count_d;
    logic       acc_q, acc_d;
    logic       ok_q;
    logic [7:0] tap_x;
    logic [7:0] tap_y;
    logic       tap_ok;
    logic       last_x;
    logic       last_y;

    median_tap_gen #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT)
    ) u_tap_gen (
        .x        (x_q),
        .y        (y_q),
        .k        (tap_q),
        .addr_x   (tap_x),
        .addr_y   (tap_y),
        .in_range (tap_ok)
    );

    assign last_x = (x_q == X_MAX);
    assign last_y = (y_q == Y_MAX);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            x_q     <= 8'd0;
            y_q     <= 8'd0;
            tap_q   <= 4'd0;
            count_q <= 4'd0;
            acc_q   <= 1'b0;
            ok_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            tap_q   <= tap_d;
            count_q <= count_d;
            acc_q   <= acc_d;
            ok_q    <= tap_ok;
        end
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        tap_d   = tap_q;
        count_d = count_q;
        acc_d   = (state_q == TAP);

        bus.pixInReady  = 1'b0;
        bus.memWrite    = 1'b0;
        bus.memDataIn   = 1'b0;
        bus.memX        = 8'd0;
        bus.memY        = 8'd0;
        bus.pixOutValid = 1'b0;
        bus.pixOut      = 1'b0;
        busy            = (state_q != IDLE);
        done            = 1'b0;

        // Read data of the tap issued last cycle lands here; out-of-range taps add nothing.
        if (acc_q) begin
            count_d = count_q + {3'd0, ok_q & bus.memDataOut};
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                    x_d     = 8'd0;
                    y_d     = 8'd0;
                    tap_d   = 4'd0;
                    count_d = 4'd0;
                end
            end
            LOAD: begin
                bus.pixInReady = 1'b1;
                bus.memX       = x_q;
                bus.memY       = y_q;
                if (bus.pixInValid) begin
                    bus.memWrite  = 1'b1;
                    bus.memDataIn = bus.pixIn;
                    if (last_x) begin
                        x_d = 8'd0;
                        if (last_y) begin
                            y_d     = 8'd0;
                            state_d = TAP;
                        end else begin
                            y_d = y_q + 8'd1;
                        end
                    end else begin
                        x_d = x_q + 8'd1;
                    end
                end
            end
            TAP: begin
                bus.memX = tap_x;
                bus.memY = tap_y;
                if (tap_q == LAST_TAP) begin
                    state_d = FLUSH;
                end else begin
                    tap_d = tap_q + 4'd1;
                end
            end
            FLUSH: begin
                state_d = EMIT;
            end
            EMIT: begin
                bus.pixOutValid = 1'b1;
                bus.pixOut      = (count_q >= MAJORITY);
                if (bus.pixOutReady) begin
                    count_d = 4'd0;
                    tap_d   = 4'd0;
                    state_d = TAP;
                    if (last_x) begin
                        x_d = 8'd0;
                        if (last_y) begin
                            y_d     = 8'd0;
                            state_d = FIN;
                        end else begin
                            y_d = y_q + 8'd1;
                        end
                    end else begin
                        x_d = x_q + 8'd1;
                    end
                end
            end
            FIN: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_median_scan_ctrl.sv
// Directed bench: a 12x10 instance for full-frame runs plus a full-size 240x180 instance for the load and first rows.
module tb_median_scan_ctrl;
    import median_pkg::*;

    localparam int SW = 12;
    localparam int SH = 10;
    localparam int SN = SW * SH;
`ifdef MEDIAN_BORDER_CLAMP_EN
    localparam logic CLAMP = 1'b1;
`else
    localparam logic CLAMP = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_s, rst_b, start_s, start_b, busy_s, busy_b, done_s, done_b;
    median_scan_ctrl_if ifs ();
    median_scan_ctrl_if ifb ();

    median_scan_ctrl #(.WIDTH(SW), .HEIGHT(SH)) dut_s (
        .clk(clk), .reset(rst_s), .start(start_s), .bus(ifs), .busy(busy_s), .done(done_s)
    );
    median_scan_ctrl dut_b (
        .clk(clk), .reset(rst_b), .start(start_b), .bus(ifb), .busy(busy_b), .done(done_b)
    );

    // Behavioural single-port RAMs with one cycle of read latency.
    logic mem_s [0:65535];
    logic mem_b [0:65535];
    logic rd_s, rd_b;
    always @(posedge clk) begin
        if (ifs.memWrite) mem_s[{ifs.memY, ifs.memX}] <= ifs.memDataIn;
        rd_s <= mem_s[{ifs.memY, ifs.memX}];
        if (ifb.memWrite) mem_b[{ifb.memY, ifb.memX}] <= ifb.memDataIn;
        rd_b <= mem_b[{ifb.memY, ifb.memX}];
    end
    assign ifs.memDataOut = rd_s;
    assign ifb.memDataOut = rd_b;

    int         out_cnt, done_cnt, wr_cnt;
    logic [7:0] last_wx, last_wy;
    logic       out_log [0:4095];
    int         outb_cnt, wrb_cnt;
    logic [7:0] lastb_wx, lastb_wy;
    logic       outb_log [0:511];

    always @(negedge clk) begin
        if (!rst_s) begin
            out_cnt <= 0; done_cnt <= 0; wr_cnt <= 0; last_wx <= 8'd0; last_wy <= 8'd0;
        end else begin
            if (ifs.pixOutValid && ifs.pixOutReady) begin
                if (out_cnt < 4096) out_log[out_cnt] <= ifs.pixOut;
                out_cnt <= out_cnt + 1;
            end
            if (done_s) done_cnt <= done_cnt + 1;
            if (ifs.memWrite) begin
                wr_cnt <= wr_cnt + 1; last_wx <= ifs.memX; last_wy <= ifs.memY;
            end
        end
        if (!rst_b) begin
            outb_cnt <= 0; wrb_cnt <= 0; lastb_wx <= 8'd0; lastb_wy <= 8'd0;
        end else begin
            if (ifb.pixOutValid && ifb.pixOutReady) begin
                if (outb_cnt < 512) outb_log[outb_cnt] <= ifb.pixOut;
                outb_cnt <= outb_cnt + 1;
            end
            if (ifb.memWrite) begin
                wrb_cnt <= wrb_cnt + 1; lastb_wx <= ifb.memX; lastb_wy <= ifb.memY;
            end
        end
    end

    int   checks, errors;
    logic img [0:SH-1][0:SW-1];

    task automatic check1(string tag, logic obs, logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic checkn(string tag, int obs, int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic model(int x, int y);
        int n;
        int xx;
        int yy;
        n = 0;
        for (int dy = -1; dy <= 1; dy++) begin
            for (int dx = -1; dx <= 1; dx++) begin
                xx = x + dx;
                yy = y + dy;
                if (CLAMP) begin
                    if (xx < 0) xx = 0;
                    if (xx > SW - 1) xx = SW - 1;
                    if (yy < 0) yy = 0;
                    if (yy > SH - 1) yy = SH - 1;
                    n += int'(img[yy][xx]);
                end else if (xx >= 0 && xx < SW && yy >= 0 && yy < SH) begin
                    n += int'(img[yy][xx]);
                end
            end
        end
        return (n >= 5);
    endfunction

    task automatic set_img(int pat);
        for (int y = 0; y < SH; y++) begin
            for (int x = 0; x < SW; x++) begin
                case (pat)
                    0:       img[y][x] = 1'b1;
                    1:       img[y][x] = (x == 5 && y == 4);
                    2:       img[y][x] = ((x + y) % 2) == 1;
                    3:       img[y][x] = ((x * 3 + y * 5) % 7) < 3;
                    default: img[y][x] = ((x / 2 + y) % 2) == 1;
                endcase
            end
        end
    endtask

    task automatic pulse_reset_s();
        rst_s = 1'b0;
        tick();
        tick();
        rst_s = 1'b1;
        tick();
    endtask

    task automatic load_small(bit toggle);
        int guard;
        start_s = 1'b1;
        tick();
        start_s = 1'b0;
        for (int y = 0; y < SH; y++) begin
            for (int x = 0; x < SW; x++) begin
                ifs.pixIn      = img[y][x];
                ifs.pixInValid = 1'b1;
                guard = 0;
                while (!ifs.pixInReady && guard < 20) begin
                    tick();
                    guard++;
                end
                tick();
                if (toggle) begin
                    ifs.pixInValid = 1'b0;
                    ifs.pixIn      = 1'b0;
                    tick();
                end
            end
        end
        ifs.pixInValid = 1'b0;
        ifs.pixIn      = 1'b0;
    endtask

    task automatic wait_done(string tag, int budget);
        int n;
        n = 0;
        while (done_cnt == 0 && n < budget) begin
            tick();
            n++;
        end
        repeat (3) tick();
        checkn({tag, "_done_pulses"}, done_cnt, 1);
        checkn({tag, "_out_count"}, out_cnt, SN);
    endtask

    task automatic compare_frame(string tag);
        int mism;
        mism = 0;
        for (int i = 0; i < SN; i++) begin
            if (out_log[i] !== model(i % SW, i / SW)) mism++;
        end
        checkn({tag, "_mismatches"}, mism, 0);
    endtask

    initial begin
        int   n;
        int   ones;
        logic held;
        logic stable;

        checks = 0;
        errors = 0;
        rst_s = 1'b0; rst_b = 1'b0; start_s = 1'b0; start_b = 1'b0;
        ifs.pixInValid = 1'b0; ifs.pixIn = 1'b0; ifs.pixOutReady = 1'b1;
        ifb.pixInValid = 1'b0; ifb.pixIn = 1'b0; ifb.pixOutReady = 1'b1;
        #22;

        check1("rst_pixInReady", ifs.pixInReady, 1'b0);
        check1("rst_memWrite", ifs.memWrite, 1'b0);
        check1("rst_memDataIn", ifs.memDataIn, 1'b0);
        checkn("rst_memX", int'(ifs.memX), 0);
        checkn("rst_memY", int'(ifs.memY), 0);
        check1("rst_pixOutValid", ifs.pixOutValid, 1'b0);
        check1("rst_pixOut", ifs.pixOut, 1'b0);
        check1("rst_busy", busy_s, 1'b0);
        check1("rst_done", done_s, 1'b0);
        check1("rst_b_busy", busy_b, 1'b0);
        rst_s = 1'b1;
        rst_b = 1'b1;
        tick();

        // Full-size instance: all-ones load at one pixel per cycle, then the first two filtered rows.
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        check1("big_ready_in_load", ifb.pixInReady, 1'b1);
        ifb.pixIn      = 1'b1;
        ifb.pixInValid = 1'b1;
        repeat (43200) tick();
        ifb.pixInValid = 1'b0;
        checkn("big_write_count", wrb_cnt, 43200);
        checkn("big_last_wx", int'(lastb_wx), 239);
        checkn("big_last_wy", int'(lastb_wy), 179);
        n = 0;
        while (outb_cnt < 242 && n < 3000) begin
            tick();
            n++;
        end
        checkn("big_out_reached", outb_cnt, 242);
        check1("big_corner_0_0", outb_log[0], CLAMP);
        check1("big_edge_5_0", outb_log[5], 1'b1);
        check1("big_interior_1_1", outb_log[241], 1'b1);
        ones = 0;
        for (int i = 0; i < 240; i++) ones += int'(outb_log[i]);
        checkn("big_row0_ones", ones, CLAMP ? 240 : 238);
        rst_b = 1'b0;
        tick();
        check1("big_busy_after_reset", busy_b, 1'b0);

        // All-ones frame.
        set_img(0);
        load_small(1'b0);
        checkn("ones_writes", wr_cnt, SN);
        wait_done("ones", 2000);
        check1("ones_corner_0_0", out_log[0], CLAMP);
        check1("ones_edge_5_0", out_log[5], 1'b1);
        check1("ones_interior_6_5", out_log[5 * SW + 6], 1'b1);
        check1("ones_idle_after", busy_s, 1'b0);
        compare_frame("ones");

        // Isolated salt pixel is removed.
        pulse_reset_s();
        set_img(1);
        load_small(1'b0);
        wait_done("salt", 2000);
        ones = 0;
        for (int i = 0; i < SN; i++) ones += int'(out_log[i]);
        checkn("salt_output_ones", ones, 0);

        // Checkerboard with a 7-cycle output stall at pixel (10,8).
        pulse_reset_s();
        set_img(2);
        load_small(1'b0);
        n = 0;
        while (out_cnt < 8 * SW + 10 && n < 1500) begin
            tick();
            n++;
        end
        ifs.pixOutReady = 1'b0;
        n = 0;
        while (!ifs.pixOutValid && n < 20) begin
            tick();
            n++;
        end
        check1("stall_valid_seen", ifs.pixOutValid, 1'b1);
        held   = ifs.pixOut;
        stable = 1'b1;
        repeat (6) begin
            tick();
            if (ifs.pixOutValid !== 1'b1 || ifs.pixOut !== held) stable = 1'b0;
        end
        check1("stall_output_stable", stable, 1'b1);
        check1("stall_value_10_8", held, 1'b0);
        checkn("stall_no_accept", out_cnt, 8 * SW + 10);
        ifs.pixOutReady = 1'b1;
        wait_done("checker", 2000);
        check1("checker_4_3", out_log[3 * SW + 4], 1'b1);
        check1("checker_3_3", out_log[3 * SW + 3], 1'b0);
        compare_frame("checker");

        // Input valid toggled every other cycle.
        pulse_reset_s();
        set_img(3);
        load_small(1'b1);
        checkn("toggle_writes", wr_cnt, SN);
        checkn("toggle_last_wx", int'(last_wx), SW - 1);
        checkn("toggle_last_wy", int'(last_wy), SH - 1);
        wait_done("toggle", 2000);
        compare_frame("toggle");

        // Asynchronous reset in TAP at pixel (3,3), then a fresh run.
        pulse_reset_s();
        set_img(4);
        load_small(1'b0);
        n = 0;
        while (out_cnt < 3 * SW + 3 && n < 1000) begin
            tick();
            n++;
        end
        repeat (3) tick();
        check1("midrun_busy", busy_s, 1'b1);
        checkn("midrun_tap3_x", int'(ifs.memX), 2);
        checkn("midrun_tap3_y", int'(ifs.memY), 3);
        #2;
        rst_s = 1'b0;
        #1;
        check1("midrun_pixInReady", ifs.pixInReady, 1'b0);
        check1("midrun_memWrite", ifs.memWrite, 1'b0);
        checkn("midrun_memX", int'(ifs.memX), 0);
        checkn("midrun_memY", int'(ifs.memY), 0);
        check1("midrun_pixOutValid", ifs.pixOutValid, 1'b0);
        check1("midrun_pixOut", ifs.pixOut, 1'b0);
        check1("midrun_busy_low", busy_s, 1'b0);
        check1("midrun_done", done_s, 1'b0);
        tick();
        tick();
        rst_s = 1'b1;
        tick();
        load_small(1'b0);
        wait_done("rerun", 2000);
        compare_frame("rerun");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
